// File: rtl/scan_code_gen.sv
// Steps a 3-bit channel code through the enabled bits of an 8-bit mask.
// Each code is held for a programmable dwell, and a one-cycle pulse marks each wrap.
module scan_code_gen #(
    parameter int DWELL_W = 8
) (
    input  logic               clk,
    input  logic               rstN,
    input  logic               inEnable,
    input  logic               inHold,
    input  logic [7:0]         inMask,
    input  logic [DWELL_W-1:0] inDwell,
    output logic [2:0]         outData,
    output logic               outValid,
    output logic               outWrap
);

    localparam logic ST_IDLE  = 1'b0;
    localparam logic ST_DWELL = 1'b1;

    logic               state_q, state_d;
    logic [2:0]         code_q, code_d;
    logic               valid_q, valid_d;
    logic               wrap_q, wrap_d;
    logic [DWELL_W-1:0] cnt_q, cnt_d;

    logic [7:0] above_mask;
    logic [2:0] first_code;
    logic [2:0] next_code;
    logic       mask_empty;

    function automatic logic [2:0] lowest_set(input logic [7:0] m);
        logic [2:0] idx;
        idx = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (m[i]) idx = 3'(i);
        end
        return idx;
    endfunction

    // Channels strictly above the current code; empty means the next advance wraps.
    for (genvar gi = 0; gi < 8; gi++) begin : g_above
        assign above_mask[gi] = inMask[gi] & (code_q < 3'(gi));
    end

    assign mask_empty = (inMask == 8'd0);
    assign first_code = lowest_set(inMask);
    assign next_code  = (above_mask != 8'd0) ? lowest_set(above_mask) : first_code;

    always_comb begin
        state_d = state_q;
        code_d  = code_q;
        valid_d = valid_q;
        cnt_d   = cnt_q;
        wrap_d  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                valid_d = 1'b0;
                if (inEnable && !mask_empty) begin
                    state_d = ST_DWELL;
                    code_d  = first_code;
                    valid_d = 1'b1;
                    cnt_d   = '0;
                end
            end
            default: begin
                if (!inEnable || mask_empty) begin
                    state_d = ST_IDLE;
                    valid_d = 1'b0;
                end else if (inHold) begin
                    cnt_d = cnt_q;
                end else if (cnt_q >= inDwell) begin
                    // >= lets a mid-dwell reduction of inDwell take effect at once
                    code_d = next_code;
                    cnt_d  = '0;
                    wrap_d = (next_code <= code_q);
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            state_q <= ST_IDLE;
            code_q  <= 3'd0;
            valid_q <= 1'b0;
            wrap_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            code_q  <= code_d;
            valid_q <= valid_d;
            wrap_q  <= wrap_d;
            cnt_q   <= cnt_d;
        end
    end

    assign outData  = code_q;
    assign outValid = valid_q;
    assign outWrap  = wrap_q;

endmodule

// File: tb/tb_scan_code_gen.sv
// Self-checking bench for scan_code_gen: vector table plus hand-written multi-cycle sequences,
// with expected outputs queued at drive time and popped after each clock edge.
module tb_scan_code_gen;

    logic       clk;
    logic       rstN;
    logic       inEnable;
    logic       inHold;
    logic [7:0] inMask;
    logic [7:0] inDwell;
    logic [2:0] outData;
    logic       outValid;
    logic       outWrap;

    scan_code_gen #(.DWELL_W(8)) dut (
        .clk      (clk),
        .rstN     (rstN),
        .inEnable (inEnable),
        .inHold   (inHold),
        .inMask   (inMask),
        .inDwell  (inDwell),
        .outData  (outData),
        .outValid (outValid),
        .outWrap  (outWrap)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [2:0] d;
        logic       v;
        logic       w;
    } exp_t;

    typedef struct packed {
        logic       en;
        logic       hold;
        logic [7:0] mask;
        logic [7:0] dwell;
        logic [2:0] d;
        logic       v;
        logic       w;
    } vec_t;

    exp_t exp_q[$];
    vec_t tbl[23];
    int   n_cmp = 0;
    int   n_err = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
        end
    endtask

    // Drive one cycle of stimulus, queue the expected post-edge outputs, then compare.
    task automatic step(input logic en, input logic hold, input logic [7:0] mask,
                        input logic [7:0] dwell, input logic [2:0] ed, input logic ev,
                        input logic ew, input string name);
        exp_t e;
        @(negedge clk);
        inEnable = en;
        inHold   = hold;
        inMask   = mask;
        inDwell  = dwell;
        exp_q.push_back('{d: ed, v: ev, w: ew});
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        chk({name, ".data"},  32'(outData),  32'(e.d));
        chk({name, ".valid"}, 32'(outValid), 32'(e.v));
        chk({name, ".wrap"},  32'(outWrap),  32'(e.w));
        $display("step %-10s en=%0b hold=%0b mask=%02h dwell=%0d -> data=%0d valid=%0b wrap=%0b",
                 name, en, hold, mask, dwell, outData, outValid, outWrap);
    endtask

    task automatic do_reset();
        @(negedge clk);
        inEnable = 1'b0;
        inHold   = 1'b0;
        inMask   = 8'd0;
        inDwell  = 8'd0;
        rstN     = 1'b0;
        #2;
        rstN = 1'b1;
    endtask

    function automatic vec_t mk(input logic en, input logic [7:0] mask, input logic [7:0] dwell,
                                input logic [2:0] d, input logic v, input logic w);
        vec_t r;
        r.en = en; r.hold = 1'b0; r.mask = mask; r.dwell = dwell;
        r.d = d; r.v = v; r.w = w;
        return r;
    endfunction

    initial begin
        // Sparse mask at dwell 0, then single channel, empty mask and re-entry.
        tbl[0]  = mk(1, 8'hA4, 0, 2, 1, 0);
        tbl[1]  = mk(1, 8'hA4, 0, 5, 1, 0);
        tbl[2]  = mk(1, 8'hA4, 0, 7, 1, 0);
        tbl[3]  = mk(1, 8'hA4, 0, 2, 1, 1);
        tbl[4]  = mk(1, 8'hA4, 0, 5, 1, 0);
        tbl[5]  = mk(1, 8'hA4, 0, 7, 1, 0);
        tbl[6]  = mk(1, 8'hA4, 0, 2, 1, 1);
        tbl[7]  = mk(1, 8'h08, 3, 2, 1, 0);
        tbl[8]  = mk(1, 8'h08, 3, 2, 1, 0);
        tbl[9]  = mk(1, 8'h08, 3, 2, 1, 0);
        tbl[10] = mk(1, 8'h08, 3, 3, 1, 0);
        tbl[11] = mk(1, 8'h08, 3, 3, 1, 0);
        tbl[12] = mk(1, 8'h08, 3, 3, 1, 0);
        tbl[13] = mk(1, 8'h08, 3, 3, 1, 0);
        tbl[14] = mk(1, 8'h08, 3, 3, 1, 1);
        tbl[15] = mk(1, 8'h08, 3, 3, 1, 0);
        tbl[16] = mk(1, 8'h08, 3, 3, 1, 0);
        tbl[17] = mk(1, 8'h08, 3, 3, 1, 0);
        tbl[18] = mk(1, 8'h08, 3, 3, 1, 1);
        tbl[19] = mk(1, 8'h00, 3, 3, 0, 0);
        tbl[20] = mk(1, 8'h00, 3, 3, 0, 0);
        tbl[21] = mk(1, 8'h08, 3, 3, 1, 0);
        tbl[22] = mk(1, 8'h08, 3, 3, 1, 0);

        rstN = 1'b0; inEnable = 1'b0; inHold = 1'b0; inMask = 8'd0; inDwell = 8'd0;
        #1;
        chk("rst.data",  32'(outData),  32'd0);
        chk("rst.valid", 32'(outValid), 32'd0);
        chk("rst.wrap",  32'(outWrap),  32'd0);
        #10;
        rstN = 1'b1;

        // Full scan, dwell 2, with decoder one-hot check.
        do_reset();
        for (int k = 1; k <= 27; k++) begin
            logic [2:0] ed;
            logic       ew;
            logic [7:0] one;
            ed  = 3'(((k - 1) / 3) % 8);
            ew  = (k > 1) && ((k - 1) % 3 == 0) && (ed == 3'd0);
            step(1, 0, 8'hFF, 8'd2, ed, 1'b1, ew, "full");
            one = 8'd1 << outData;
            chk("full.dec", 32'(one), 32'(8'd1 << ed));
        end

        do_reset();
        for (int i = 0; i < 23; i++) begin
            step(tbl[i].en, tbl[i].hold, tbl[i].mask, tbl[i].dwell,
                 tbl[i].d, tbl[i].v, tbl[i].w, "table");
        end

        // Hold for 5 cycles stretches code 0 to 16 cycles; then shrink dwell with counter at 7.
        do_reset();
        for (int k = 1; k <= 16; k++) begin
            step(1, (k >= 4 && k <= 8), 8'hFF, 8'd10, 3'd0, 1'b1, 1'b0, "hold");
        end
        step(1, 0, 8'hFF, 8'd10, 3'd1, 1'b1, 1'b0, "hold.adv");
        for (int k = 0; k < 7; k++) begin
            step(1, 0, 8'hFF, 8'd10, 3'd1, 1'b1, 1'b0, "pre");
        end
        step(1, 0, 8'hFF, 8'd3, 3'd2, 1'b1, 1'b0, "shrink");
        for (int k = 0; k < 3; k++) begin
            step(1, 0, 8'hFF, 8'd3, 3'd2, 1'b1, 1'b0, "dw3");
        end
        step(1, 0, 8'hFF, 8'd3, 3'd3, 1'b1, 1'b0, "dw3.adv");

        // Stop while on code 5, then restart from the lowest set bit.
        do_reset();
        step(1, 0, 8'h26, 8'd1, 3'd1, 1'b1, 1'b0, "ss");
        step(1, 0, 8'h26, 8'd1, 3'd1, 1'b1, 1'b0, "ss");
        step(1, 0, 8'h26, 8'd1, 3'd2, 1'b1, 1'b0, "ss");
        step(1, 0, 8'h26, 8'd1, 3'd2, 1'b1, 1'b0, "ss");
        step(1, 0, 8'h26, 8'd1, 3'd5, 1'b1, 1'b0, "ss");
        step(1, 0, 8'h26, 8'd1, 3'd5, 1'b1, 1'b0, "ss");
        step(0, 0, 8'h26, 8'd1, 3'd5, 1'b0, 1'b0, "stop");
        step(0, 0, 8'h26, 8'd1, 3'd5, 1'b0, 1'b0, "stopped");
        step(1, 0, 8'h26, 8'd1, 3'd1, 1'b1, 1'b0, "restart");

        // Asynchronous reset between edges.
        do_reset();
        for (int k = 0; k < 4; k++) begin
            step(1, 0, 8'hFF, 8'd0, 3'(k), 1'b1, 1'b0, "pre_rst");
        end
        #1;
        rstN = 1'b0;
        #1;
        chk("arst.data",  32'(outData),  32'd0);
        chk("arst.valid", 32'(outValid), 32'd0);
        chk("arst.wrap",  32'(outWrap),  32'd0);
        rstN = 1'b1;
        step(0, 0, 8'hFF, 8'd0, 3'd0, 1'b0, 1'b0, "post_rst");
        step(1, 0, 8'hFF, 8'd0, 3'd0, 1'b1, 1'b0, "reenter");
        step(1, 0, 8'hFF, 8'd0, 3'd1, 1'b1, 1'b0, "reenter");

        chk("queue.empty", 32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/scan_code_gen.md
# scan_code_gen

Sequential code generator placed directly upstream of the 3-to-8 one-hot decoder. It steps a 3-bit channel code through the channels enabled in an 8-bit mask, holds each code for a programmable dwell time, and flags each completed pass. `outData` connects straight to the decoder's `inData`, so exactly one decoder output is active per dwell period. Typical uses are LED/digit multiplexing and round-robin channel selection.

## Interface
- `DWELL_W`, default 8: width of the dwell counter and of `inDwell`.

- `clk`  in  1  single clock; all state updates on its rising edge.
- `rstN`  in  1  asynchronous, active-low reset.
- `inEnable`  in  1  scan enable.
- `inHold`  in  1  freezes the current code and dwell counter.
- `inMask`  in  8  channel enable mask; bit i set means code i takes part in the scan.
- `inDwell`  in  DWELL_W  dwell length; each code is held for inDwell+1 cycles.
- `outData`  out  3  current channel code, fed to the decoder.
- `outValid`  out  1  outData is an active scan code.
- `outWrap`  out  1  one-cycle pulse, high in the cycle a wrapped-around code first appears.

## Operation
- Reset (asynchronous, while rstN=0):
  - outData=3'b000, outValid=0, outWrap=0.
  - Dwell counter cleared; state IDLE.
- States: IDLE and DWELL.
- Next-code function next(c, m): the lowest set index of m strictly above c. If there is none, the lowest set index of m overall; this case is a wrap.
- IDLE:
  - Condition: inEnable=1 and inMask≠0.
  - Action: outData=lowest set index of inMask, outValid=1, counter=0, go to DWELL.
  - Otherwise stay in IDLE with outValid=0.
  - outWrap stays 0 on this entry.
- DWELL, evaluated each cycle in this priority order:
  1. inEnable=0 → IDLE, outValid=0, outData holds its last value.
  2. inMask=0 → IDLE, outValid=0, outData holds.
  3. inHold=1 → counter and outData unchanged.
  4. counter ≥ inDwell → outData=next(outData, inMask), counter=0. outWrap=1 if the new code is ≤ the old code, else 0.
  5. Otherwise counter increments by 1.
- The ≥ comparison makes a reduction of inDwell mid-dwell advance on the next cycle instead of waiting for the counter to wrap.
- The counter never exceeds 2^DWELL_W−1.
- Mask handling:
  - inMask is sampled only at advance and entry cycles.
  - Clearing the bit of the current channel does not shorten its dwell; the code simply leaves at the next advance.
- A single-bit mask re-selects the same code every inDwell+1 cycles, with outWrap pulsing at each re-selection.
- outWrap is 0 in every cycle that is not an advance cycle.

## Timing
- Outputs are registered. No combinational path from inputs to outputs.
- Start latency: inEnable sampled high at edge N → outValid=1 after edge N.
- Dwell: every code is held for exactly inDwell+1 cycles when inHold=0. Each cycle with inHold=1 adds one cycle.
- inDwell=0: the code changes every cycle.
- Stop latency: inEnable sampled low → outValid=0 after that same edge.
- Restart after stop always begins from the lowest set bit, never from the held code.
- Asserting rstN=0 mid-scan clears all outputs immediately. Scanning resumes only via the IDLE entry rule after rstN=1.

## Test plan
- Full scan:
  - Stimulus: reset, then inMask=8'hFF, inDwell=2, inEnable=1.
  - Required: outData runs 0,1,…,7,0 with 3 cycles per code; outValid=1 from the cycle after enable; outWrap pulses once, in the first cycle of the second 0.
- Sparse mask:
  - Stimulus: inMask=8'b1010_0100, inDwell=0.
  - Required: outData sequence 2,5,7,2,5,…; outWrap high on each return to 2.
- Single channel and empty mask:
  - Stimulus: inMask=8'h08, inDwell=3.
  - Required: outData=3 constant, outWrap every 4 cycles.
  - Then inMask=0 → outValid=0 next cycle and state IDLE.
- Hold and dwell shrink:
  - Stimulus: inDwell=10, inHold=1 for 5 cycles mid-dwell.
  - Required: that code lasts 16 cycles.
  - Then, with counter=7, set inDwell=3 → advance on the next cycle.
- Stop/restart and async reset:
  - Stimulus: inEnable dropped while outData=5.
  - Required: outValid=0 next cycle, outData stays 5; re-enable restarts from the lowest set bit.
  - Stimulus: rstN pulsed low between clock edges.
  - Required: outputs go to 0 without waiting for a clock edge.
- Decoder integration:
  - Stimulus: connect outData to the 3-to-8 decoder with inMask=8'hFF.
  - Required: decoder output is one-hot each cycle and walks 8'h01→8'h80→8'h01.
